// File: rtl/lfsr_period_checker.sv
// lfsr_period_checker
// Watches the sample stream of an LFSR and measures how many samples pass
// before the first (reference) value reappears. Reports the measured period,
// whether it equals the expected maximal length, and sticky error/lock-up
// flags. Measurement is continuous: the same reference is reused after every
// match, and a fresh reference is taken after a runaway (no repeat within
// 2^WIDTH samples).
module lfsr_period_checker #(
    parameter int WIDTH           = 8,
    parameter int EXPECTED_PERIOD = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_clear,
    output logic [WIDTH:0]   o_period,
    output logic             o_period_valid,
    output logic             o_locked,
    output logic             o_error,
    output logic             o_stuck
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    localparam logic [WIDTH:0] EXP_PERIOD_C = (WIDTH + 1)'(EXPECTED_PERIOD);
    // 2^WIDTH: one more sample than any legal period can need
    localparam logic [WIDTH:0] TIMEOUT_C    = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] CNT_ONE_C    = {{WIDTH{1'b0}}, 1'b1};

    logic [0:0]       state_r,        state_nxt_s;
    logic [WIDTH:0]   cnt_r,          cnt_nxt_s;
    logic [WIDTH-1:0] ref_r,          ref_nxt_s;
    logic [WIDTH:0]   period_r,       period_nxt_s;
    logic             period_valid_r, period_valid_nxt_s;
    logic             locked_r,       locked_nxt_s;
    logic             error_r,        error_nxt_s;
    logic             stuck_r,        stuck_nxt_s;

    logic [WIDTH:0]   cnt_inc_s;
    logic             match_s;
    logic             zero_s;
    logic             timeout_s;

    assign cnt_inc_s = cnt_r + CNT_ONE_C;
    assign match_s   = (i_value == ref_r);
    assign zero_s    = (i_value == {WIDTH{1'b0}});
    assign timeout_s = (!match_s) && (cnt_inc_s == TIMEOUT_C);

    // Next-state and next-output computation for one sample (or clear)
    always_comb begin
        state_nxt_s        = state_r;
        cnt_nxt_s          = cnt_r;
        ref_nxt_s          = ref_r;
        period_nxt_s       = period_r;
        period_valid_nxt_s = 1'b0;
        locked_nxt_s       = locked_r;
        error_nxt_s        = error_r;
        stuck_nxt_s        = stuck_r;

        if (i_clear) begin
            // Clear wins over a coincident sample; that sample is dropped
            state_nxt_s  = ST_IDLE;
            cnt_nxt_s    = {(WIDTH + 1){1'b0}};
            locked_nxt_s = 1'b0;
            error_nxt_s  = 1'b0;
            stuck_nxt_s  = 1'b0;
        end else if (i_valid) begin
            case (state_r)
                ST_IDLE: begin
                    ref_nxt_s   = i_value;
                    cnt_nxt_s   = {(WIDTH + 1){1'b0}};
                    state_nxt_s = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (match_s) begin
                        period_nxt_s       = cnt_inc_s;
                        period_valid_nxt_s = 1'b1;
                        cnt_nxt_s          = {(WIDTH + 1){1'b0}};
                        if (cnt_inc_s == EXP_PERIOD_C) begin
                            locked_nxt_s = 1'b1;
                        end else begin
                            locked_nxt_s = 1'b0;
                            error_nxt_s  = 1'b1;
                        end
                    end else if (timeout_s) begin
                        // Runaway: restart from the current sample
                        error_nxt_s  = 1'b1;
                        locked_nxt_s = 1'b0;
                        ref_nxt_s    = i_value;
                        cnt_nxt_s    = {(WIDTH + 1){1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {(WIDTH + 1){1'b0}};
                end
            endcase
            // All-zero lock-up sample overrides any lock gained above
            stuck_nxt_s  = stuck_nxt_s | zero_s;
            error_nxt_s  = error_nxt_s | zero_s;
            locked_nxt_s = locked_nxt_s & ~zero_s;
        end else begin
            // No sample this cycle: everything holds, pulse drops
            period_valid_nxt_s = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {(WIDTH + 1){1'b0}};
            ref_r          <= {WIDTH{1'b0}};
            period_r       <= {(WIDTH + 1){1'b0}};
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
            error_r        <= 1'b0;
            stuck_r        <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            ref_r          <= ref_nxt_s;
            period_r       <= period_nxt_s;
            period_valid_r <= period_valid_nxt_s;
            locked_r       <= locked_nxt_s;
            error_r        <= error_nxt_s;
            stuck_r        <= stuck_nxt_s;
        end
    end

    assign o_period       = period_r;
    assign o_period_valid = period_valid_r;
    assign o_locked       = locked_r;
    assign o_error        = error_r;
    assign o_stuck        = stuck_r;

endmodule
